mult8: RTL and testbench

Unsigned 8×8 sequential shift-and-add multiplier producing a 16-bit product. It runs free-running from reset with no start handshake. It repeatedly samples its operands, computes the product over eight add/shift iterations, and publishes the result on a registered output that holds until the next result. It is a small arithmetic leaf block for datapaths where a 10-cycle result latency is acceptable in exchange for a single adder.

---
 rtl/mult8.sv | 73 +++++++
 tb/tb_mult8.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mult8.sv
// Unsigned 8x8 sequential shift-and-add multiplier: one 16-bit product every
// 10 clocks (LOAD, 8x CALC, DONE), free-running with no start handshake.
module mult8 (
  input  logic        clk,
  input  logic        sig,
  input  logic [7:0]  ina,
  input  logic [7:0]  inb,
  output logic [15:0] out
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] mcand;
  logic [15:0] acc;
  logic [7:0]  mplier;
  logic [2:0]  cnt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge sig) begin
    if (!sig) state <= LOAD;
    else      state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    state_nxt = CALC;
      CALC:    if (cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Reset clears the result too, so an abandoned computation never leaks out.
  always_ff @(posedge clk or negedge sig) begin
    if (!sig) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          mcand  <= {8'b0, ina};
          mplier <= inb;
          acc    <= '0;
          cnt    <= '0;
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
        end
        DONE: begin
          out <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult8.sv
// Self-checking bench for mult8: directed scenarios plus random operands
// compared against a period-level behavioural model (product = a*b at LOAD).
module tb_mult8;

  logic        clk;
  logic        sig;
  logic [7:0]  ina;
  logic [7:0]  inb;
  logic [15:0] out;

  int total = 0;
  int bad   = 0;

  mult8 dut (
    .clk (clk),
    .sig (sig),
    .ina (ina),
    .inb (inb),
    .out (out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Behavioural model: each 10-edge period samples a*b on its first edge and
  // publishes it on its tenth; next_phase is the phase of the upcoming edge.
  int          next_phase = 0;
  logic [15:0] pending    = '0;
  logic [15:0] exp_out    = '0;

  always @(posedge clk or negedge sig) begin
    if (!sig) begin
      next_phase = 0;
      exp_out    = '0;
    end else begin
      if (next_phase == 0) pending = 16'(ina) * 16'(inb);
      if (next_phase == 9) exp_out = pending;
      next_phase = (next_phase + 1) % 10;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_load();
    int n = 0;
    @(negedge clk);
    while (next_phase != 0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (next_phase != 0) begin
      bad++;
      $display("FAIL wait_load: phase=%0d required=0 after bounded wait", next_phase);
    end
  endtask

  task automatic test_reset();
    sig = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ina = 8'($urandom);
      inb = 8'($urandom);
      @(negedge clk);
      total++;
      if (out !== 16'h0000) begin
        bad++;
        $display("FAIL reset_hold[%0d]: out=%h required=0000", i, out);
      end
    end
  endtask

  task automatic test_basic();
    ina = 8'd13;
    inb = 8'd11;
    #3 sig = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++;
      if (out !== ((k >= 9) ? 16'd143 : 16'd0)) begin
        bad++;
        $display("FAIL basic E%0d: out=%0d required=%0d", k, out, (k >= 9) ? 143 : 0);
      end
    end
  endtask

  task automatic test_extremes();
    logic [7:0]  a_tab [3] = '{8'd255, 8'd0,   8'd1};
    logic [7:0]  b_tab [3] = '{8'd255, 8'd200, 8'd200};
    logic [15:0] p_tab [3] = '{16'hFE01, 16'h0000, 16'h00C8};
    for (int t = 0; t < 3; t++) begin
      ina = a_tab[t];
      inb = b_tab[t];
      repeat (30) @(negedge clk);
      total++;
      if (out !== p_tab[t]) begin
        bad++;
        $display("FAIL extreme %0dx%0d: out=%h required=%h", a_tab[t], b_tab[t], out, p_tab[t]);
      end
    end
  endtask

  task automatic test_midchange();
    wait_load();
    ina = 8'd6;
    inb = 8'd7;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 2) begin
        ina = 8'd9;
        inb = 8'd9;
      end
      if (k == 9 || k == 18) begin
        total++;
        if (out !== 16'd42) begin
          bad++;
          $display("FAIL midchange E%0d: out=%0d required=42", k, out);
        end
      end
      if (k == 19) begin
        total++;
        if (out !== 16'd81) begin
          bad++;
          $display("FAIL midchange E19: out=%0d required=81", out);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_load();
    ina = 8'd200;
    inb = 8'd3;
    repeat (15) @(negedge clk);  // after E4 of the second 200x3 period
    total++;
    if (out !== 16'd600) begin
      bad++;
      $display("FAIL reset_mid pre: out=%0d required=600", out);
    end
    sig = 1'b0;
    #1;
    total++;
    if (out !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid async clear: out=%0d required=0", out);
    end
    @(negedge clk);
    sig = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (out !== ((k >= 9) ? 16'd600 : 16'd0)) begin
        bad++;
        $display("FAIL reset_mid E%0d: out=%0d required=%0d", k, out, (k >= 9) ? 600 : 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a_tab [3] = '{8'd2, 8'd100, 8'd255};
    logic [7:0]  b_tab [3] = '{8'd3, 8'd100, 8'd1};
    logic [15:0] p_tab [3] = '{16'd6, 16'd10000, 16'd255};
    wait_load();
    for (int t = 0; t < 3; t++) begin
      ina = a_tab[t];
      inb = b_tab[t];
      repeat (10) @(negedge clk);  // LOAD of next period is upcoming
      total++;
      if (out !== p_tab[t]) begin
        bad++;
        $display("FAIL back_to_back[%0d]: out=%0d required=%0d", t, out, p_tab[t]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ina = 8'($urandom);
        inb = 8'($urandom);
      end
      @(negedge clk);
      total++;
      if (out !== exp_out) begin
        bad++;
        $display("FAIL random[%0d]: out=%h required=%h", i, out, exp_out);
      end
    end
  endtask

  initial begin
    sig = 1'b0;
    ina = '0;
    inb = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_midchange();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
